// File: rtl/fifo_fwft_sync_pkg.sv
// Shared read-mode encodings, default geometry and per-cycle operation record
// for the single-clock FIFO family.
package fifo_fwft_sync_pkg;

    typedef enum logic {
        FIFO_MODE_REG  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 4;

    typedef struct packed {
        logic wr_en;
        logic rd_en;
        logic wr_reject;
        logic rd_reject;
    } fifo_op_t;

    function automatic bit levels_ok(input int almost_empty, input int almost_full,
                                     input int depth);
        return (almost_empty > 0) && (almost_empty < almost_full) && (almost_full <= depth);
    endfunction

endpackage

// File: rtl/fifo_fwft_sync_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module fifo_mem
    import fifo_fwft_sync_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_fwft_sync.sv
// Single-clock FIFO with selectable registered / first-word-fall-through read,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_fwft_sync
    import fifo_fwft_sync_pkg::*;
#(
    parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH      = DEFAULT_ADDRESS_WIDTH,
    parameter int FWFT               = 0,
    parameter int ALMOST_FULL_LEVEL  = (2 ** ADDRESS_WIDTH) - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   write,
    input  logic [DATA_WIDTH-1:0]  dataIn,
    input  logic                   read,
    output logic [DATA_WIDTH-1:0]  dataOut,
    output logic                   full,
    output logic                   empty,
    output logic                   almostFull,
    output logic                   almostEmpty,
    output logic [ADDRESS_WIDTH:0] filled,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = ADDRESS_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_LEVEL  = PW'(ALMOST_FULL_LEVEL);
    localparam logic [PW-1:0] AE_LEVEL  = PW'(ALMOST_EMPTY_LEVEL);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    if (!levels_ok(ALMOST_EMPTY_LEVEL, ALMOST_FULL_LEVEL, DEPTH)) begin : g_bad_levels
        $error("fifo_fwft_sync: need 0 < ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= DEPTH");
    end
    if (FWFT != int'(FIFO_MODE_REG) && FWFT != int'(FIFO_MODE_FWFT)) begin : g_bad_mode
        $error("fifo_fwft_sync: FWFT must be 0 or 1");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic [PW-1:0] filled_w;
    logic          full_w, empty_w;
    fifo_op_t      op;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Wrap bit makes full (difference == DEPTH) distinguishable from empty.
    assign filled_w = wr_ptr_q - rd_ptr_q;
    assign full_w   = (filled_w == DEPTH_CNT);
    assign empty_w  = (filled_w == '0);

    always_comb begin
        op          = '0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (enable) begin
            if (flush) begin
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end else begin
                op.wr_en     = write & ~full_w;
                op.rd_en     = read & ~empty_w;
                op.wr_reject = write & full_w;
                op.rd_reject = read & empty_w;
                if (op.wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (op.rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
                overflow_d  = overflow_q | op.wr_reject;
                underflow_d = underflow_q | op.rd_reject;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (op.wr_en & ~reset),
        .wr_addr(wr_ptr_q[ADDRESS_WIDTH-1:0]),
        .wr_data(dataIn),
        .rd_addr(rd_ptr_q[ADDRESS_WIDTH-1:0]),
        .rd_data(mem_rd_data)
    );

    if (FWFT == int'(FIFO_MODE_FWFT)) begin : g_fwft
        assign dataOut = empty_w ? '0 : mem_rd_data;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

        always_comb begin
            data_out_d = data_out_q;
            if (op.rd_en) data_out_d = mem_rd_data;
        end

        always_ff @(posedge clk) begin
            if (reset) data_out_q <= '0;
            else       data_out_q <= data_out_d;
        end

        assign dataOut = data_out_q;
    end

    assign full        = full_w;
    assign empty       = empty_w;
    assign almostFull  = (filled_w >= AF_LEVEL);
    assign almostEmpty = (filled_w <= AE_LEVEL);
    assign filled      = filled_w;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_fwft_sync.sv
// Drives a registered-read and a FWFT instance with identical stimulus and
// checks both against a queue-based model of the FIFO.
module tb_fifo_fwft_sync;

    logic       clk = 1'b0;
    logic       reset = 1'b0, enable = 1'b0, flush = 1'b0, write = 1'b0, read = 1'b0;
    logic [7:0] dataIn = '0;

    logic [7:0] r_dout, f_dout;
    logic       r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0] r_filled, f_filled;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    bit         m_ovf = 0, m_udf = 0;
    logic [7:0] m_dreg = '0;

    always #5 clk = ~clk;

    fifo_fwft_sync #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .FWFT(0)) dut_reg (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush), .write(write),
        .dataIn(dataIn), .read(read), .dataOut(r_dout), .full(r_full), .empty(r_empty),
        .almostFull(r_af), .almostEmpty(r_ae), .filled(r_filled),
        .overflow(r_ovf), .underflow(r_udf));

    fifo_fwft_sync #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush), .write(write),
        .dataIn(dataIn), .read(read), .dataOut(f_dout), .full(f_full), .empty(f_empty),
        .almostFull(f_af), .almostEmpty(f_ae), .filled(f_filled),
        .overflow(f_ovf), .underflow(f_udf));

    function automatic logic [10:0] exp_status();
        int sz = mq.size();
        return {sz == 16, sz == 0, sz >= 14, sz <= 2, m_ovf, m_udf, 5'(sz)};
    endfunction

    function automatic logic [7:0] exp_fwft_dout();
        return (mq.size() > 0) ? mq[0] : 8'h00;
    endfunction

    // Advance the model on the current inputs, then let the DUTs take the edge.
    task automatic cycle();
        int sz = mq.size();
        if (reset) begin
            mq.delete(); m_ovf = 0; m_udf = 0; m_dreg = '0;
        end else if (enable) begin
            if (flush) begin
                mq.delete(); m_ovf = 0; m_udf = 0;
            end else begin
                if (write && sz == 16) m_ovf = 1;
                if (read && sz == 0)   m_udf = 1;
                if (read && sz > 0)    m_dreg = mq.pop_front();
                if (write && sz < 16)  mq.push_back(dataIn);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; enable = 1; flush = 0; write = 0; read = 0;
    endtask

    task automatic test_reset();
        reset = 1; enable = 1;
        cycle();
        idle();
        checks++;
        if ({r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_filled} !== 11'b01_01_00_00000) begin
            errors++;
            $display("FAIL reset_status reg got %b want %b",
                     {r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_filled}, 11'b01_01_00_00000);
        end
        checks++;
        if ({f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_filled} !== 11'b01_01_00_00000) begin
            errors++;
            $display("FAIL reset_status fwft got %b want %b",
                     {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_filled}, 11'b01_01_00_00000);
        end
        checks++;
        if (r_dout !== 8'h00 || f_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout got %h/%h want 00/00", r_dout, f_dout);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 17; i++) begin
            write = 1; dataIn = 8'(i);
            cycle();
            checks++;
            if ({r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_filled} !== exp_status() ||
                {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_filled} !== exp_status()) begin
                errors++;
                $display("FAIL fill_status[%0d] got %b/%b want %b", i,
                         {r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_filled},
                         {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_filled}, exp_status());
            end
            checks++;
            if (f_dout !== exp_fwft_dout() || r_dout !== m_dreg) begin
                errors++;
                $display("FAIL fill_dout[%0d] got %h/%h want %h/%h", i, r_dout, f_dout,
                         m_dreg, exp_fwft_dout());
            end
        end
        write = 0;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 17; i++) begin
            read = 1;
            cycle();
            checks++;
            if (r_dout !== m_dreg || f_dout !== exp_fwft_dout()) begin
                errors++;
                $display("FAIL drain_dout[%0d] got %h/%h want %h/%h", i, r_dout, f_dout,
                         m_dreg, exp_fwft_dout());
            end
            checks++;
            if ({r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_filled} !== exp_status() ||
                {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_filled} !== exp_status()) begin
                errors++;
                $display("FAIL drain_status[%0d] got %b/%b want %b", i,
                         {r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_filled},
                         {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_filled}, exp_status());
            end
        end
        read = 0;
        checks++;
        if (r_dout !== 8'h0F || r_udf !== 1'b1 || r_ovf !== 1'b1) begin
            errors++;
            $display("FAIL drain_end got dout=%h udf=%b ovf=%b want 0f 1 1", r_dout, r_udf, r_ovf);
        end
    endtask

    task automatic test_fwft_single();
        flush = 1;
        cycle();
        flush = 0; write = 1; dataIn = 8'hA5;
        cycle();
        write = 0;
        checks++;
        if (f_dout !== 8'hA5 || f_filled !== 5'd1 || f_ovf !== 1'b0 || f_udf !== 1'b0) begin
            errors++;
            $display("FAIL fwft_single got dout=%h filled=%0d want a5 1", f_dout, f_filled);
        end
        cycle();
        checks++;
        if (f_dout !== 8'hA5) begin
            errors++;
            $display("FAIL fwft_hold got %h want a5", f_dout);
        end
        read = 1;
        cycle();
        read = 0;
        checks++;
        if (f_dout !== 8'h00 || f_empty !== 1'b1 || r_dout !== 8'hA5) begin
            errors++;
            $display("FAIL fwft_pop got fdout=%h empty=%b rdout=%h want 00 1 a5",
                     f_dout, f_empty, r_dout);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            write = 1; dataIn = 8'($urandom);
            cycle();
        end
        for (int i = 0; i < 40; i++) begin
            write = 1; read = 1; dataIn = 8'($urandom);
            cycle();
            checks++;
            if (r_filled !== 5'd3 || f_filled !== 5'd3 || r_dout !== m_dreg ||
                f_dout !== exp_fwft_dout()) begin
                errors++;
                $display("FAIL wrap[%0d] got filled=%0d/%0d dout=%h/%h want 3 %h/%h", i,
                         r_filled, f_filled, r_dout, f_dout, m_dreg, exp_fwft_dout());
            end
        end
        write = 0; read = 0;
    endtask

    task automatic test_full_rw();
        while (mq.size() < 16) begin
            write = 1; dataIn = 8'($urandom);
            cycle();
        end
        write = 1; read = 1; dataIn = 8'h5A;
        cycle();
        write = 0; read = 0;
        checks++;
        if (r_filled !== 5'd15 || r_ovf !== 1'b1 || r_dout !== m_dreg ||
            {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_filled} !== exp_status()) begin
            errors++;
            $display("FAIL full_rw got filled=%0d ovf=%b dout=%h want 15 1 %h",
                     r_filled, r_ovf, r_dout, m_dreg);
        end
        flush = 1;
        cycle();
        flush = 0;
        checks++;
        if (r_filled !== 5'd0 || r_ovf !== 1'b0 || r_udf !== 1'b0 || r_empty !== 1'b1 ||
            f_dout !== 8'h00 || r_dout !== m_dreg) begin
            errors++;
            $display("FAIL flush got filled=%0d ovf=%b empty=%b fdout=%h rdout=%h want 0 0 1 00 %h",
                     r_filled, r_ovf, r_empty, f_dout, r_dout, m_dreg);
        end
    endtask

    task automatic test_enable_hold();
        logic [10:0] before_st;
        logic [7:0]  before_r, before_f;
        for (int i = 0; i < 5; i++) begin
            write = 1; dataIn = 8'($urandom);
            cycle();
        end
        write = 0; read = 1;
        cycle();
        before_st = exp_status(); before_r = m_dreg; before_f = exp_fwft_dout();
        enable = 0; write = 1; read = 1; flush = 1;
        for (int i = 0; i < 5; i++) begin
            dataIn = 8'($urandom);
            cycle();
            checks++;
            if ({r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_filled} !== before_st ||
                {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_filled} !== before_st ||
                r_dout !== before_r || f_dout !== before_f) begin
                errors++;
                $display("FAIL enable_hold[%0d] got %b dout=%h/%h want %b %h/%h", i,
                         {r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_filled}, r_dout, f_dout,
                         before_st, before_r, before_f);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        while (mq.size() < 7) begin
            write = 1; dataIn = 8'($urandom);
            cycle();
        end
        write = 0; read = 1;
        cycle();
        write = 1; read = 0;
        cycle();
        checks++;
        if (r_filled !== 5'd7) begin
            errors++;
            $display("FAIL reset_mid_prime got filled=%0d want 7", r_filled);
        end
        reset = 1; write = 1; read = 1; dataIn = 8'hFF;
        cycle();
        idle();
        checks++;
        if ({r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_filled} !== 11'b01_01_00_00000 ||
            {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_filled} !== 11'b01_01_00_00000 ||
            r_dout !== 8'h00 || f_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid got %b dout=%h/%h want 01010000000 00/00",
                     {r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_filled}, r_dout, f_dout);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 39) == 0);
            write  = ($urandom_range(0, 99) < 55);
            read   = ($urandom_range(0, 99) < 45);
            dataIn = 8'($urandom);
            cycle();
            checks++;
            if ({r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_filled} !== exp_status() ||
                {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_filled} !== exp_status() ||
                r_dout !== m_dreg || f_dout !== exp_fwft_dout()) begin
                errors++;
                $display("FAIL random[%0d] got %b/%b dout=%h/%h want %b %h/%h", i,
                         {r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_filled},
                         {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_filled},
                         r_dout, f_dout, exp_status(), m_dreg, exp_fwft_dout());
            end
        end
        idle();
    endtask

    initial begin
        #2;
        test_reset();
        test_fill();
        test_drain();
        test_fwft_single();
        test_wrap();
        test_full_rw();
        test_enable_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_fwft_sync.md
Name: fifo_fwft_sync

Overview:
Parametrised synchronous FIFO: next generation of the team's single-clock FIFO buffer.
Adds selectable read mode (registered-read or first-word-fall-through), programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
Sits between producer/consumer blocks in one clock domain; default depth 16 × 8 bits.

Parameters:
DATA_WIDTH, 8, width of each stored element
ADDRESS_WIDTH, 4, log2 of depth; depth DEPTH = 2**ADDRESS_WIDTH
FWFT, 0, 0 = registered read (1-cycle latency), 1 = first-word-fall-through
ALMOST_FULL_LEVEL, DEPTH-2, almostFull asserted when filled >= this
ALMOST_EMPTY_LEVEL, 2, almostEmpty asserted when filled <= this

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  reset, synchronous, active-high
enable  input  1  global enable; low freezes all state
flush  input  1  synchronous clear of contents and error flags
write  input  1  write request
dataIn  input  DATA_WIDTH  write data
read  input  1  read/pop request
dataOut  output  DATA_WIDTH  read data
full  output  1  filled == DEPTH
empty  output  1  filled == 0
almostFull  output  1  filled >= ALMOST_FULL_LEVEL
almostEmpty  output  1  filled <= ALMOST_EMPTY_LEVEL
filled  output  ADDRESS_WIDTH+1  occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Interface fixed: one clock clk; reset is synchronous and active-high.
- Pointers readPointer/writePointer are ADDRESS_WIDTH+1 bits; memory indexed by the low ADDRESS_WIDTH bits; MSB is the wrap bit; increments wrap modulo 2**(ADDRESS_WIDTH+1).
- filled = writePointer - readPointer (modular, ADDRESS_WIDTH+1 bits); full iff filled == DEPTH exactly; empty iff filled == 0.
- Reset: pointers 0, dataOut 0, overflow 0, underflow 0. Resulting outputs: empty 1, full 0, filled 0, almostEmpty 1, almostFull 0. Memory array is not reset. Reset mid-operation discards all contents that cycle.
- Priority per cycle: reset > !enable (hold everything, no flag updates) > flush > read/write.
- flush (enable high): pointers to 0, overflow/underflow to 0; read/write ignored that cycle; dataOut holds in FWFT=0 mode.
- Accepted write: wrEn = write & !full. Accepted read: rdEn = read & !empty. Full/empty are evaluated on pre-edge state.
  - Full + read + write: read accepted, write rejected, overflow set.
  - Empty + read + write: write accepted, read rejected, underflow set.
  - Otherwise simultaneous accepted read and write leave filled unchanged.
- overflow set on write & full; underflow set on read & empty (enable high, no flush). Both stay set until reset or flush.
- FWFT=0: on rdEn, dataOut <= mem[readPointer] at the edge; valid the cycle after the request. dataOut holds its value otherwise, including when empty.
- FWFT=1: dataOut = mem[readPointer] combinationally while !empty; dataOut = 0 while empty. A word written into an empty FIFO appears on dataOut the cycle after the write edge. rdEn pops the head; the next word is visible immediately after that edge.
- Thresholds compared against filled combinationally. Static checks: parameters must satisfy 0 < ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= DEPTH; violation triggers $error at elaboration.

Decomposition:
- Shared header fifo_defs.vh: read-mode constants (FIFO_MODE_REG = 0, FIFO_MODE_FWFT = 1) and the default width/depth constants.
- One sub-module, fifo_mem: simple dual-port register array with synchronous write and asynchronous read, parametrised by DATA_WIDTH/ADDRESS_WIDTH. Pointer, flag and mode logic stay in fifo_fwft_sync.

Test Plan:
- Reset, then write 16 words 0x00..0x0F (FWFT=0) -> filled steps to 16; full=1 after the 16th edge; almostFull rises at filled=14; 17th write sets overflow, filled stays 16.
- Read 16 with FWFT=0 -> dataOut 0x00..0x0F, each one cycle after its read; empty=1 after last; an extra read sets underflow; dataOut holds 0x0F.
- FWFT=1: single write 0xA5 into empty FIFO -> dataOut=0xA5 next cycle with no read; read -> empty=1, dataOut=0.
- Pointer wrap: 40 interleaved read+write cycles at filled=3 -> filled constant 3, data order preserved across index 15->0.
- Full with simultaneous read+write -> one word popped, write dropped, filled=15, overflow=1. Then flush -> filled=0, overflow=0, empty=1.
- enable=0 with write/read/flush asserted for 5 cycles -> no change to filled, dataOut or flags. Reset asserted at filled=7 -> all outputs at reset values next cycle.
